multi_cycle_control: RTL
========================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter: MEM_WAIT, default 1, 1 = honor mem_ready handshake; 0 = treat mem_ready as constant 1.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26] from IR.
REQ-005 mem_ready  input  1  memory access completes this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA  output  1 each  datapath controls.
REQ-007 ALUSrcB  output  2  ALU B-operand select.
REQ-008 PCSource  output  2  next-PC select.
REQ-009 ALUOp  output  2  to ALU control: 00 add, 01 sub, 10 decode funct; 11 never driven.
REQ-010 state  output  4  current state code.
REQ-011 instr_done  output  1  one-cycle pulse on final cycle of each instruction.
REQ-012 illegal_op  output  1  one-cycle pulse on unsupported opcode.

Function
REQ-013 Moore FSM with state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RCOMP=7, BRANCH=8, JUMP=9; codes 10-15 unreachable and SHALL return to FETCH next cycle.
REQ-014 Supported opcodes: R-type 0, lw 35, sw 43, beq 4, j 2.
REQ-015 Transitions: FETCH->DECODE on mem_ready; DECODE->MEMADR (lw/sw), EXEC (R), BRANCH (beq), JUMP (j), FETCH (other); MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB on mem_ready; MEMWR->FETCH on mem_ready; EXEC->RCOMP; MEMWB, RCOMP, BRANCH, JUMP->FETCH.
REQ-016 FETCH, MEMRD, MEMWR hold state while mem_ready=0, with the access strobe held asserted.
REQ-017 FETCH outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1, so PC increments exactly once per fetch.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-019 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-020 MEMRD: MemRead=1, IorD=1.
REQ-021 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
REQ-022 MEMWR: MemWrite=1, IorD=1.
REQ-023 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
REQ-024 RCOMP: RegWrite=1, RegDst=1, MemtoReg=0.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
REQ-026 JUMP: PCWrite=1, PCSource=10.
REQ-027 Every output not listed for a state is 0; MemRead and MemWrite never both 1.
REQ-028 Opcode is sampled only in DECODE and MEMADR; changes in other states have no effect.
REQ-029 instr_done=1 in MEMWB, RCOMP, BRANCH, JUMP, and in MEMWR when mem_ready=1.
REQ-030 illegal_op=1 in DECODE when opcode is unsupported; FSM then returns to FETCH with no register or memory write.
REQ-031 Instruction latency with zero wait states: lw 5, sw 4, R 4, beq 3, j 3 cycles.

Reset
REQ-032 reset sampled high at a clock edge SHALL force state=FETCH on that edge, from any state including mid-wait.
REQ-033 While reset is high, all outputs except state SHALL be 0, and state SHALL read 0.
REQ-034 First FETCH access begins in the first cycle after reset deasserts.

Verification
REQ-035 Reset, then opcode=35, mem_ready=1 constant -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; instr_done one pulse.
REQ-036 opcode=0 -> states 0,1,6,7,0; ALUOp=10 in state 6; RegDst=1 and RegWrite=1 in state 7.
REQ-037 opcode=43, mem_ready low 3 cycles in MEMWR -> MemWrite held 4 cycles, instr_done only in the final cycle, then FETCH.
REQ-038 mem_ready low 2 cycles in FETCH -> MemRead high 3 cycles; PCWrite and IRWrite high for exactly 1 cycle.
REQ-039 opcode=4 then opcode=2 -> BRANCH with ALUOp=01, PCWriteCond=1, PCSource=01; JUMP with PCWrite=1, PCSource=10.
REQ-040 opcode=63 -> illegal_op pulses in DECODE, next state 0; reset asserted in MEMRD -> state=0 and all controls 0 on the next edge.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Main control FSM for a multi-cycle MIPS-style datapath (R-type, lw, sw, beq, j).
// Memory-access states stall on mem_ready; reset forces FETCH and masks all controls.
module multi_cycle_control #(
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RCOMP  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  logic [3:0] r_state;
  logic [3:0] w_state_next;
  logic       w_ready;
  logic       w_op_legal;

  assign w_ready    = MEM_WAIT ? mem_ready : 1'b1;
  assign w_op_legal = (opcode == OP_RTYPE) || (opcode == OP_J) || (opcode == OP_BEQ)
                   || (opcode == OP_LW) || (opcode == OP_SW);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Unused codes 10-15 fall through to the FETCH default.
  always_comb begin
    w_state_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_state_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_RTYPE:     w_state_next = S_EXEC;
          OP_BEQ:       w_state_next = S_BRANCH;
          OP_J:         w_state_next = S_JUMP;
          default:      w_state_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_state_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_state_next = w_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_state_next = S_RCOMP;
      default:  w_state_next = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    state       = r_state;
    if (reset) begin
      state = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          // PC and IR update only on the completing cycle so a stalled fetch bumps PC once.
          IRWrite = w_ready;
          PCWrite = w_ready;
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          illegal_op = ~w_op_legal;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = w_ready;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_RCOMP: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
